bench_sweep_ctrl: RTL and testbench

Sequencer that drives the radix benchmark engine through a programmable number of back-to-back runs without software intervention. It issues `start` to the engine and waits for `done` on each run. Per run it accumulates the four per-condition cycle counts (cond0 = Base2, cond1 = Base10, cond2 = Base12, cond3 = Router), counts wins per condition and reports the overall best condition. It sits between the AXI register front end and `bench_engine`, replacing the single-shot start path.

---
 rtl/bench_pkg.sv | 22 ++
 rtl/sat_acc.sv | 34 +++
 rtl/bench_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_bench_sweep_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bench_pkg.sv
// Shared definitions for the benchmark sweep sequencer: FSM encoding,
// condition indices and default timing parameters.
package bench_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_ACCUM  = 3'd3,
      ST_GAP    = 3'd4,
      ST_FIN    = 3'd5
   } state_t;

   localparam logic [1:0] COND_B2  = 2'd0;
   localparam logic [1:0] COND_B10 = 2'd1;
   localparam logic [1:0] COND_B12 = 2'd2;
   localparam logic [1:0] COND_RTR = 2'd3;

   localparam int DEF_GAP_CYC     = 4;
   localparam int DEF_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/sat_acc.sv
// Saturating accumulator: adds a zero-extended IW-bit value, pins at all-ones
// on overflow and flags the add that overflowed.
module sat_acc
   import bench_pkg::*;
#(
   parameter int W  = 48,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          add_en,
   input  logic [IW-1:0] add_val,
   output logic [W-1:0]  acc,
   output logic          sat_hit
);

   logic [W:0] sum;

   // One extra bit catches the carry out of the top of the accumulator.
   assign sum     = {1'b0, acc} + {{(W + 1 - IW){1'b0}}, add_val};
   assign sat_hit = add_en & sum[W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= sum[W] ? {W{1'b1}} : sum[W-1:0];
      end
   end

endmodule

// File: rtl/bench_sweep_ctrl.sv
// Sweep sequencer: launches the benchmark engine for a programmed number of
// runs, accumulates per-condition cycle counts and win tallies.
module bench_sweep_ctrl
   import bench_pkg::*;
#(
   parameter int RUNS_W      = 16,
   parameter int ACC_W       = 48,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RUNS_W-1:0] cfg_runs,
   input  logic              go,
   input  logic              abort,
   input  logic              clear,
   output logic              eng_start,
   input  logic              eng_done,
   input  logic [31:0]       eng_t0,
   input  logic [31:0]       eng_t1,
   input  logic [31:0]       eng_t2,
   input  logic [31:0]       eng_t3,
   input  logic [1:0]        eng_winner,
   output logic              busy,
   output logic              sweep_done,
   output logic              aborted,
   output logic              timeout_err,
   output logic              sat,
   output logic [RUNS_W-1:0] runs_done,
   output logic [ACC_W-1:0]  acc0,
   output logic [ACC_W-1:0]  acc1,
   output logic [ACC_W-1:0]  acc2,
   output logic [ACC_W-1:0]  acc3,
   output logic [RUNS_W-1:0] wins0,
   output logic [RUNS_W-1:0] wins1,
   output logic [RUNS_W-1:0] wins2,
   output logic [RUNS_W-1:0] wins3,
   output logic [1:0]        best_cond
);

   // Handshake: go/clear/abort/eng_done are single-cycle pulses taken in the
   // cycle they are high; eng_start is a one-cycle pulse, and eng_t*/eng_winner
   // are only meaningful in the cycle eng_done is high.

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int GP_W = $clog2(GAP_CYC + 1);

   state_t state, next_state;

   logic [RUNS_W-1:0] target;
   logic [TO_W-1:0]   wait_cnt, wait_nxt;
   logic [GP_W-1:0]   gap_cnt;
   logic [31:0]       t_q [4];
   logic [1:0]        win_q;
   logic [ACC_W-1:0]  acc_v [4];
   logic [RUNS_W-1:0] wins_v [4];
   logic [3:0]        acc_sat, win_sat;
   logic              clr_take, go_take, accum_en, gap_last;
   logic              set_abort, set_timeout;
   logic [1:0]        best_nxt;
   logic [RUNS_W-1:0] best_val;

   assign clr_take = (state == ST_IDLE) & clear;
   assign go_take  = (state == ST_IDLE) & go & (cfg_runs != '0);
   assign accum_en = (state == ST_ACCUM) & ~abort;
   assign gap_last = (gap_cnt == GP_W'(GAP_CYC - 1));
   // Expiry is judged on the incremented count, so a dead engine ends the
   // sweep TIMEOUT_CYC+1 cycles after its eng_start.
   assign wait_nxt = wait_cnt + TO_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state  = state;
      set_abort   = 1'b0;
      set_timeout = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (go) next_state = (cfg_runs != '0) ? ST_LAUNCH : ST_FIN;
         end
         ST_LAUNCH: begin
            if (abort) begin
               next_state = ST_FIN;
               set_abort  = 1'b1;
            end else begin
               next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               next_state = ST_FIN;
               set_abort  = 1'b1;
            end else if (eng_done) begin
               next_state = ST_ACCUM;
            end else if (wait_nxt == TO_W'(TIMEOUT_CYC - 1)) begin
               next_state  = ST_FIN;
               set_timeout = 1'b1;
            end
         end
         ST_ACCUM: begin
            if (abort) begin
               next_state = ST_FIN;
               set_abort  = 1'b1;
            end else begin
               next_state = ST_GAP;
            end
         end
         ST_GAP: begin
            if (abort) begin
               next_state = ST_FIN;
               set_abort  = 1'b1;
            end else if (gap_last) begin
               next_state = (runs_done < target) ? ST_LAUNCH : ST_FIN;
            end
         end
         ST_FIN:  next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Ties keep the lower index because only a strictly larger count displaces it.
   always_comb begin
      best_nxt = COND_B2;
      best_val = wins_v[0];
      if (wins_v[1] > best_val) begin
         best_nxt = COND_B10;
         best_val = wins_v[1];
      end
      if (wins_v[2] > best_val) begin
         best_nxt = COND_B12;
         best_val = wins_v[2];
      end
      if (wins_v[3] > best_val) begin
         best_nxt = COND_RTR;
         best_val = wins_v[3];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_start   <= 1'b0;
         busy        <= 1'b0;
         sweep_done  <= 1'b0;
         aborted     <= 1'b0;
         timeout_err <= 1'b0;
         sat         <= 1'b0;
         runs_done   <= '0;
         best_cond   <= '0;
         target      <= '0;
         wait_cnt    <= '0;
         gap_cnt     <= '0;
         win_q       <= '0;
         for (int i = 0; i < 4; i++) t_q[i] <= '0;
      end else begin
         eng_start  <= (next_state == ST_LAUNCH);
         busy       <= (next_state != ST_IDLE);
         sweep_done <= (state == ST_FIN);

         if (state == ST_LAUNCH)    wait_cnt <= '0;
         else if (state == ST_WAIT) wait_cnt <= wait_nxt;

         if (state == ST_ACCUM)    gap_cnt <= '0;
         else if (state == ST_GAP) gap_cnt <= gap_cnt + GP_W'(1);

         if (state == ST_WAIT && eng_done) begin
            t_q[0] <= eng_t0;
            t_q[1] <= eng_t1;
            t_q[2] <= eng_t2;
            t_q[3] <= eng_t3;
            win_q  <= eng_winner;
         end

         if (clr_take) begin
            runs_done <= '0;
            best_cond <= '0;
            sat       <= 1'b0;
         end
         if (go_take) begin
            target      <= cfg_runs;
            runs_done   <= '0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
            sat         <= 1'b0;
         end
         if (set_abort)   aborted     <= 1'b1;
         if (set_timeout) timeout_err <= 1'b1;
         if (accum_en)    runs_done   <= runs_done + RUNS_W'(1);
         if (|{acc_sat, win_sat}) sat <= 1'b1;
         if (state == ST_FIN) best_cond <= best_nxt;
      end
   end

   // A win tally pinned at its maximum is a saturated accumulator too.
   for (genvar i = 0; i < 4; i++) begin : g_cond
      sat_acc #(.W(ACC_W), .IW(32)) u_acc (
         .clk     (clk),
         .rst     (rst),
         .clr     (clr_take),
         .add_en  (accum_en),
         .add_val (t_q[i]),
         .acc     (acc_v[i]),
         .sat_hit (acc_sat[i])
      );
      sat_acc #(.W(RUNS_W), .IW(1)) u_win (
         .clk     (clk),
         .rst     (rst),
         .clr     (clr_take),
         .add_en  (accum_en && (win_q == 2'(i))),
         .add_val (1'b1),
         .acc     (wins_v[i]),
         .sat_hit (win_sat[i])
      );
   end

   assign acc0  = acc_v[0];
   assign acc1  = acc_v[1];
   assign acc2  = acc_v[2];
   assign acc3  = acc_v[3];
   assign wins0 = wins_v[0];
   assign wins1 = wins_v[1];
   assign wins2 = wins_v[2];
   assign wins3 = wins_v[3];

endmodule

// File: tb/tb_bench_sweep_ctrl.sv
// Bench for bench_sweep_ctrl: a stub engine with fixed latency, directed
// sweeps, and a scoreboard that checks statistics at every sweep_done.
module tb_bench_sweep_ctrl;

   localparam int RUNS_W = 16;
   localparam int ACC_W  = 33;

   logic              clk, rst;
   logic [RUNS_W-1:0] cfg_runs;
   logic              go, abort, clear;
   logic              eng_start, eng_done;
   logic [31:0]       eng_t0, eng_t1, eng_t2, eng_t3;
   logic [1:0]        eng_winner;
   logic              busy, sweep_done, aborted, timeout_err, sat;
   logic [RUNS_W-1:0] runs_done;
   logic [ACC_W-1:0]  acc0, acc1, acc2, acc3;
   logic [RUNS_W-1:0] wins0, wins1, wins2, wins3;
   logic [1:0]        best_cond;

   bench_sweep_ctrl #(
      .RUNS_W(RUNS_W), .ACC_W(ACC_W), .GAP_CYC(4), .TIMEOUT_CYC(50)
   ) dut (
      .clk(clk), .rst(rst), .cfg_runs(cfg_runs), .go(go), .abort(abort),
      .clear(clear), .eng_start(eng_start), .eng_done(eng_done),
      .eng_t0(eng_t0), .eng_t1(eng_t1), .eng_t2(eng_t2), .eng_t3(eng_t3),
      .eng_winner(eng_winner), .busy(busy), .sweep_done(sweep_done),
      .aborted(aborted), .timeout_err(timeout_err), .sat(sat),
      .runs_done(runs_done), .acc0(acc0), .acc1(acc1), .acc2(acc2),
      .acc3(acc3), .wins0(wins0), .wins1(wins1), .wins2(wins2),
      .wins3(wins3), .best_cond(best_cond)
   );

   typedef struct packed {
      logic [ACC_W-1:0]  a0, a1, a2, a3;
      logic [RUNS_W-1:0] w0, w1, w2, w3;
      logic [1:0]        best;
      logic [RUNS_W-1:0] runs;
      logic              ab, to, sa;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   start_cnt = 0;
   int   last_start = -1;
   int   start_period = 0;

   // Stub engine configuration.
   int          stub_lat = 10;
   bit          stub_hang = 1'b0;
   logic [31:0] st0, st1, st2, st3;
   logic [1:0]  win_a, win_b;
   int          stub_run = 0;
   int          abort_at = 0;
   int          stub_cnt = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- stub engine ----------------
   initial begin
      eng_done   = 1'b0;
      abort      = 1'b0;
      eng_t0     = '0;
      eng_t1     = '0;
      eng_t2     = '0;
      eng_t3     = '0;
      eng_winner = '0;
      forever begin
         @(negedge clk);
         eng_done   = 1'b0;
         abort      = 1'b0;
         eng_t0     = $urandom();
         eng_t1     = $urandom();
         eng_t2     = $urandom();
         eng_t3     = $urandom();
         eng_winner = 2'($urandom_range(3));
         if (rst) begin
            stub_cnt = 0;
         end else begin
            if (stub_cnt > 0) begin
               stub_cnt--;
               if (stub_cnt == 0) begin
                  eng_done   = 1'b1;
                  eng_t0     = st0;
                  eng_t1     = st1;
                  eng_t2     = st2;
                  eng_t3     = st3;
                  eng_winner = stub_run[0] ? win_b : win_a;
                  stub_run++;
                  if (stub_run == abort_at) abort = 1'b1;
               end
            end
            if (eng_start && !stub_hang) stub_cnt = stub_lat;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && eng_start) begin
         start_cnt++;
         if (last_start >= 0) start_period = cyc - last_start;
         last_start = cyc;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
      end
   endtask

   function automatic exp_t mk(input logic [ACC_W-1:0] a0, a1, a2, a3,
                               input logic [RUNS_W-1:0] w0, w1, w2, w3,
                               input logic [1:0] b, input logic [RUNS_W-1:0] r,
                               input logic ab, to, sa);
      exp_t e;
      e.a0 = a0; e.a1 = a1; e.a2 = a2; e.a3 = a3;
      e.w0 = w0; e.w1 = w1; e.w2 = w2; e.w3 = w3;
      e.best = b; e.runs = r; e.ab = ab; e.to = to; e.sa = sa;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && sweep_done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_done: got sweep_done=1, want no pending sweep");
         end else begin
            mon_e = exp_q.pop_front();
            chk("acc0", 64'(acc0), 64'(mon_e.a0));
            chk("acc1", 64'(acc1), 64'(mon_e.a1));
            chk("acc2", 64'(acc2), 64'(mon_e.a2));
            chk("acc3", 64'(acc3), 64'(mon_e.a3));
            chk("wins0", 64'(wins0), 64'(mon_e.w0));
            chk("wins1", 64'(wins1), 64'(mon_e.w1));
            chk("wins2", 64'(wins2), 64'(mon_e.w2));
            chk("wins3", 64'(wins3), 64'(mon_e.w3));
            chk("best_cond", 64'(best_cond), 64'(mon_e.best));
            chk("runs_done", 64'(runs_done), 64'(mon_e.runs));
            chk("aborted", 64'(aborted), 64'(mon_e.ab));
            chk("timeout_err", 64'(timeout_err), 64'(mon_e.to));
            chk("sat", 64'(sat), 64'(mon_e.sa));
            chk("busy_at_done", 64'(busy), 64'(0));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_stub(input logic [31:0] t0, t1, t2, t3,
                           input logic [1:0] wa, wb, input bit hang, input int ab_at);
      st0 = t0; st1 = t1; st2 = t2; st3 = t3;
      win_a = wa; win_b = wb;
      stub_hang = hang;
      abort_at = ab_at;
      stub_run = 0;
   endtask

   // Returns at the negedge of cycle 1 (one cycle after go was sampled).
   task automatic do_go(input int runs, input exp_t e, input bit push_it);
      @(negedge clk);
      cfg_runs = RUNS_W'(runs);
      go = 1'b1;
      if (push_it) exp_q.push_back(e);
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget, output int at);
      bit seen;
      seen = 1'b0;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sweep_done) begin
            seen = 1'b1;
            at = cyc;
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s: no sweep_done within %0d cycles", nm, budget);
      end
   endtask

   // ---------------- main sequence ----------------
   int s0, d0, st, at;

   initial begin
      rst = 1'b1;
      go = 1'b0;
      clear = 1'b0;
      cfg_runs = '0;
      set_stub(0, 0, 0, 0, 0, 0, 1'b0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_eng_start", 64'(eng_start), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_sweep_done", 64'(sweep_done), 0);
      chk("rst_aborted", 64'(aborted), 0);
      chk("rst_timeout", 64'(timeout_err), 0);
      chk("rst_sat", 64'(sat), 0);
      chk("rst_runs", 64'(runs_done), 0);
      chk("rst_acc0", 64'(acc0), 0);
      chk("rst_wins3", 64'(wins3), 0);
      chk("rst_best", 64'(best_cond), 0);

      // 5 runs, fixed winner 3
      set_stub(100, 80, 90, 50, 3, 3, 1'b0, 0);
      s0 = start_cnt;
      d0 = done_cnt;
      do_go(5, mk(500, 400, 450, 250, 0, 0, 0, 5, 3, 5, 0, 0, 0), 1'b1);
      chk("a_busy_c1", 64'(busy), 1);
      chk("a_start_c1", 64'(eng_start), 1);
      wait_done("a_done", 500, at);
      @(negedge clk);
      chk("a_done_one_cycle", 64'(sweep_done), 0);
      chk("a_start_count", 64'(start_cnt - s0), 5);
      chk("a_done_count", 64'(done_cnt - d0), 1);
      chk("a_start_period", 64'(start_period), 16);

      // zero-run sweep: no engine start, stats untouched
      s0 = start_cnt;
      do_go(0, mk(500, 400, 450, 250, 0, 0, 0, 5, 3, 5, 0, 0, 0), 1'b1);
      chk("b_start_c1", 64'(eng_start), 0);
      chk("b_busy_c1", 64'(busy), 1);
      chk("b_done_c1", 64'(sweep_done), 0);
      @(negedge clk);
      chk("b_done_c2", 64'(sweep_done), 1);
      chk("b_busy_c2", 64'(busy), 0);
      repeat (3) @(negedge clk);
      chk("b_start_count", 64'(start_cnt - s0), 0);

      // engine never answers
      do_clear();
      set_stub(1, 1, 1, 1, 0, 0, 1'b1, 0);
      do_go(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
      st = cyc;
      wait_done("c_done", 200, at);
      chk("c_timeout_latency", 64'(at - st), 51);
      stub_hang = 1'b0;

      // abort coincident with the 3rd eng_done
      do_clear();
      set_stub(100, 80, 90, 50, 3, 3, 1'b0, 3);
      do_go(5, mk(200, 160, 180, 100, 0, 0, 0, 2, 3, 2, 1, 0, 0), 1'b1);
      wait_done("d_done", 500, at);
      abort_at = 0;

      // alternating winners tie -> lowest index
      do_clear();
      set_stub(10, 20, 30, 40, 1, 2, 1'b0, 0);
      do_go(4, mk(40, 80, 120, 160, 0, 2, 2, 0, 1, 4, 0, 0, 0), 1'b1);
      wait_done("e_done", 500, at);

      // saturation of a 33-bit accumulator, then clear
      do_clear();
      set_stub(32'hFFFF_FFFF, 1, 2, 3, 0, 0, 1'b0, 0);
      do_go(3, mk(33'h1_FFFF_FFFF, 3, 6, 9, 3, 0, 0, 0, 0, 3, 0, 0, 1), 1'b1);
      wait_done("f_done", 500, at);
      do_clear();
      chk("f_clr_acc0", 64'(acc0), 0);
      chk("f_clr_acc3", 64'(acc3), 0);
      chk("f_clr_wins0", 64'(wins0), 0);
      chk("f_clr_runs", 64'(runs_done), 0);
      chk("f_clr_sat", 64'(sat), 0);

      // build nonzero stats, then reset while waiting on the engine
      set_stub(7, 8, 9, 10, 2, 2, 1'b0, 0);
      do_go(1, mk(7, 8, 9, 10, 0, 0, 1, 0, 2, 1, 0, 0, 0), 1'b1);
      wait_done("g_done", 200, at);
      set_stub(1, 1, 1, 1, 0, 0, 1'b1, 0);
      do_go(2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      repeat (5) @(negedge clk);
      chk("g_busy_before_rst", 64'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("g_rst_eng_start", 64'(eng_start), 0);
      chk("g_rst_busy", 64'(busy), 0);
      chk("g_rst_acc0", 64'(acc0), 0);
      chk("g_rst_wins2", 64'(wins2), 0);
      chk("g_rst_runs", 64'(runs_done), 0);
      chk("g_rst_best", 64'(best_cond), 0);
      @(negedge clk);
      rst = 1'b0;
      stub_hang = 1'b0;
      repeat (3) @(negedge clk);

      chk("sb_drained", 64'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
